// File: rtl/usb_tx_pkg.sv
// Shared types and byte constants for the USB packet transmit controller.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        TT_DATA0 = 3'd0,
        TT_DATA1 = 3'd1,
        TT_ACK   = 3'd2,
        TT_NAK   = 3'd3,
        TT_STALL = 3'd4
    } tx_type_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_FETCH,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'h D2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_SYNC = 3'd1;
    localparam logic [2:0] PH_PID  = 3'd2;
    localparam logic [2:0] PH_DATA = 3'd3;
    localparam logic [2:0] PH_CRC  = 3'd4;
    localparam logic [2:0] PH_EOP  = 3'd5;

    function automatic logic is_data(input logic [2:0] t);
        return (t == TT_DATA0) || (t == TT_DATA1);
    endfunction

endpackage

// File: rtl/usb_tx_pid_enc.sv
// Combinational map from packet type to PID byte plus a legality flag.
// Zero latency; no flow control.
module usb_tx_pid_enc
    import usb_tx_pkg::*;
(
    input  logic [2:0] tx_type,
    output logic [7:0] pid,
    output logic       legal
);

    always_comb begin
        pid   = 8'h00;
        legal = 1'b1;
        case (tx_type)
            TT_DATA0: pid = PID_DATA0;
            TT_DATA1: pid = PID_DATA1;
            TT_ACK:   pid = PID_ACK;
            TT_NAK:   pid = PID_NAK;
            TT_STALL: pid = PID_STALL;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB packet transmit sequencer: SYNC, PID, payload, CRC16, EOP; one byte per load/taken handshake.
// Optional tx_abort under USB_TX_ABORT_EN; each byte waits for byte_taken, payload waits for data_valid.
module usb_tx_ctrl
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tx_start,
`ifdef USB_TX_ABORT_EN
    input  logic             tx_abort,
`endif
    input  logic [2:0]       tx_type,
    input  logic [CNT_W-1:0] tx_size,
    output logic             data_req,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic [7:0]       byte_out,
    output logic             byte_load,
    input  logic             byte_taken,
    output logic             crc_clear,
    output logic             crc_enable,
    input  logic [15:0]      crc_in,
    output logic             eop_req,
    input  logic             eop_done,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_error,
    output logic [2:0]       state_out
);

    state_t           state;
    logic [2:0]       type_q;
    logic [CNT_W-1:0] size_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [2:0]       enc_type;
    logic [7:0]       pid;
    logic             legal;
    logic             oversize;
    logic             taken;

    // The encoder checks the incoming request in IDLE and supplies the latched PID afterwards.
    assign enc_type  = (state == ST_IDLE) ? tx_type : type_q;
    assign oversize  = is_data(tx_type) && (tx_size > CNT_W'(MAX_BYTES));
    assign count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign taken     = byte_taken && !byte_load;

    usb_tx_pid_enc u_pid_enc (
        .tx_type (enc_type),
        .pid     (pid),
        .legal   (legal)
    );

`ifdef USB_TX_ABORT_EN
    logic aborted;
    logic abort_now;
    assign abort_now = tx_abort && (state inside {ST_SYNC, ST_PID, ST_FETCH, ST_DATA,
                                                  ST_CRC_LO, ST_CRC_HI});
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            type_q     <= 3'd0;
            size_q     <= '0;
            count      <= '0;
            data_req   <= 1'b0;
            byte_out   <= 8'h00;
            byte_load  <= 1'b0;
            crc_clear  <= 1'b0;
            crc_enable <= 1'b0;
            eop_req    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            state_out  <= PH_IDLE;
`ifdef USB_TX_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            data_req   <= 1'b0;
            byte_load  <= 1'b0;
            crc_clear  <= 1'b0;
            crc_enable <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
`ifdef USB_TX_ABORT_EN
            if (abort_now) begin
                state     <= ST_EOP;
                state_out <= PH_EOP;
                eop_req   <= 1'b1;
                aborted   <= 1'b1;
            end else
`endif
            begin
                case (state)
                    ST_IDLE: begin
                        if (tx_start) begin
                            if (legal && !oversize) begin
                                type_q    <= tx_type;
                                size_q    <= tx_size;
                                count     <= '0;
                                crc_clear <= 1'b1;
                                tx_busy   <= 1'b1;
                                state     <= ST_SYNC;
                                state_out <= PH_SYNC;
                                byte_out  <= SYNC_BYTE;
                                byte_load <= 1'b1;
                            end else begin
                                tx_error <= 1'b1;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (taken) begin
                            state     <= ST_PID;
                            state_out <= PH_PID;
                            byte_out  <= pid;
                            byte_load <= 1'b1;
                        end
                    end
                    ST_PID: begin
                        if (taken) begin
                            if (!is_data(type_q)) begin
                                state     <= ST_EOP;
                                state_out <= PH_EOP;
                                eop_req   <= 1'b1;
                            end else if (size_q == '0) begin
                                state     <= ST_CRC_LO;
                                state_out <= PH_CRC;
                                byte_out  <= crc_in[7:0];
                                byte_load <= 1'b1;
                            end else begin
                                state     <= ST_FETCH;
                                state_out <= PH_DATA;
                                data_req  <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (data_valid) begin
                            state      <= ST_DATA;
                            state_out  <= PH_DATA;
                            byte_out   <= data_in;
                            byte_load  <= 1'b1;
                            crc_enable <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (taken) begin
                            count <= count_nxt;
                            if (count_nxt == size_q) begin
                                state     <= ST_CRC_LO;
                                state_out <= PH_CRC;
                                byte_out  <= crc_in[7:0];
                                byte_load <= 1'b1;
                            end else begin
                                state     <= ST_FETCH;
                                state_out <= PH_DATA;
                                data_req  <= 1'b1;
                            end
                        end
                    end
                    ST_CRC_LO: begin
                        if (taken) begin
                            state     <= ST_CRC_HI;
                            state_out <= PH_CRC;
                            byte_out  <= crc_in[15:8];
                            byte_load <= 1'b1;
                        end
                    end
                    ST_CRC_HI: begin
                        if (taken) begin
                            state     <= ST_EOP;
                            state_out <= PH_EOP;
                            eop_req   <= 1'b1;
                        end
                    end
                    ST_EOP: begin
                        if (eop_done) begin
                            state     <= ST_DONE;
                            state_out <= PH_EOP;
                            eop_req   <= 1'b0;
`ifdef USB_TX_ABORT_EN
                            if (aborted) tx_error <= 1'b1;
                            else         tx_done  <= 1'b1;
`else
                            tx_done   <= 1'b1;
`endif
                        end
                    end
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        state_out <= PH_IDLE;
                        tx_busy   <= 1'b0;
`ifdef USB_TX_ABORT_EN
                        aborted   <= 1'b0;
`endif
                    end
                    default: begin
                        state     <= ST_IDLE;
                        state_out <= PH_IDLE;
                        eop_req   <= 1'b0;
                        tx_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Scoreboard bench for usb_tx_ctrl: directed packets, serialiser/buffer/EOP responders, event monitor.
module tb_usb_tx_ctrl;

    localparam int MAXB = 64;
    localparam int CW   = $clog2(MAXB + 1);

    localparam int EV_BYTE = 0;
    localparam int EV_EOP  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
        logic [2:0] ph;
    } ev_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          tx_start = 1'b0;
    logic [2:0]    tx_type = 3'd0;
    logic [CW-1:0] tx_size = '0;
    logic          data_req;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_load;
    logic          byte_taken = 1'b0;
    logic          crc_clear;
    logic          crc_enable;
    logic [15:0]   crc_in = 16'h0000;
    logic          eop_req;
    logic          eop_done = 1'b0;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_error;
    logic [2:0]    state_out;
`ifdef USB_TX_ABORT_EN
    logic          tx_abort = 1'b0;
`endif

    ev_t        exp_q[$];
    logic [7:0] buf_q[$];
    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int req_cnt = 0;
    int crcen_cnt = 0;
    int clr_cnt = 0;
    int dly = 1;

    always #5 clk = ~clk;

    usb_tx_ctrl #(.MAX_BYTES(MAXB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
`ifdef USB_TX_ABORT_EN
        .tx_abort   (tx_abort),
`endif
        .tx_type    (tx_type),
        .tx_size    (tx_size),
        .data_req   (data_req),
        .data_in    (data_in),
        .data_valid (data_valid),
        .byte_out   (byte_out),
        .byte_load  (byte_load),
        .byte_taken (byte_taken),
        .crc_clear  (crc_clear),
        .crc_enable (crc_enable),
        .crc_in     (crc_in),
        .eop_req    (eop_req),
        .eop_done   (eop_done),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .state_out  (state_out)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] val, input logic [2:0] ph);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.ph   = ph;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [7:0] val, input logic [2:0] ph);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d val=%02h required no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && e.val != val) ||
                (kind <= EV_EOP && e.ph != ph)) begin
                errors++;
                $display("FAIL event actual kind=%0d val=%02h ph=%0d required kind=%0d val=%02h ph=%0d",
                         kind, val, ph, e.kind, e.val, e.ph);
            end
        end
    endtask

    // Monitor: every observable DUT event is matched against the head of the scoreboard queue.
    initial begin : monitor
        logic eop_q;
        eop_q = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (byte_load) begin
                    load_cnt++;
                    got_ev(EV_BYTE, byte_out, state_out);
                end
                if (eop_req && !eop_q) got_ev(EV_EOP, 8'h00, state_out);
                if (tx_done)  got_ev(EV_DONE, 8'h00, 3'd0);
                if (tx_error) got_ev(EV_ERR, 8'h00, 3'd0);
                if (data_req)  req_cnt++;
                if (crc_clear) clr_cnt++;
                if (crc_enable) begin
                    crcen_cnt++;
                    chk("crc_enable_with_load", int'(byte_load), 1);
                end
            end
            eop_q = eop_req;
        end
    end

    // Serialiser, data buffer and EOP encoder models.
    initial begin : responders
        int tk, dv, ep;
        tk = 0; dv = 0; ep = 0;
        forever begin
            @(posedge clk);
            #1;
            byte_taken = 1'b0;
            data_valid = 1'b0;
            eop_done   = 1'b0;
            if (!n_rst) begin
                tk = 0; dv = 0; ep = 0;
            end else begin
                if (byte_load) tk = 2;
                else if (tk > 0) begin
                    tk--;
                    if (tk == 0) byte_taken = 1'b1;
                end
                if (data_req) dv = dly;
                else if (dv > 0) begin
                    dv--;
                    if (dv == 0) begin
                        data_valid = 1'b1;
                        if (buf_q.size() > 0) data_in = buf_q.pop_front();
                        else                  data_in = 8'hEE;
                    end
                end
                if (ep > 0) begin
                    ep--;
                    if (ep == 0) eop_done = 1'b1;
                end else if (eop_req) ep = 2;
            end
        end
    end

    task automatic start(input logic [2:0] t, input int s);
        @(posedge clk);
        #1;
        tx_type  = t;
        tx_size  = CW'(s);
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || tx_busy) && n < max);
        chk(name, int'(exp_q.size() != 0 || tx_busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_loads(input int target, input int max, input string name);
        int n;
        n = 0;
        while (load_cnt < target && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, int'(load_cnt >= target), 1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_outs"}, int'({data_req, byte_load, crc_clear, crc_enable,
                                   eop_req, tx_busy, tx_done, tx_error}), 0);
        chk({name, "_byte_out"}, int'(byte_out), 0);
        chk({name, "_state_out"}, int'(state_out), 0);
    endtask

    task automatic check_no_pulse(input string name);
        chk(name, int'({data_req, byte_load, crc_clear, crc_enable, tx_done, tx_error}), 0);
    endtask

    task automatic handshake(input logic [2:0] t, input logic [7:0] pid, input string name);
        int r0;
        r0 = req_cnt;
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, pid, 3'd2);
        expect_ev(EV_EOP, 8'h00, 3'd5);
        expect_ev(EV_DONE, 8'h00, 3'd0);
        start(t, 0);
        wait_idle(200, name);
        chk({name, "_no_data_req"}, req_cnt - r0, 0);
    endtask

    task automatic reject(input logic [2:0] t, input int s, input string name);
        int busy_seen, l0;
        busy_seen = 0;
        l0 = load_cnt;
        expect_ev(EV_ERR, 8'h00, 3'd0);
        start(t, s);
        repeat (4) begin
            @(negedge clk);
            if (tx_busy) busy_seen = 1;
        end
        chk({name, "_busy"}, busy_seen, 0);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_no_load"}, load_cnt - l0, 0);
    endtask

    initial begin : main
        int r0, c0, k0, l0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check_no_pulse("post_release");

        handshake(3'd2, 8'hD2, "ack");

        // DATA1, three bytes
        crc_in = 16'h1234;
        buf_q.push_back(8'hA5); buf_q.push_back(8'h01); buf_q.push_back(8'hFF);
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, 8'h4B, 3'd2);
        expect_ev(EV_BYTE, 8'hA5, 3'd3);
        expect_ev(EV_BYTE, 8'h01, 3'd3);
        expect_ev(EV_BYTE, 8'hFF, 3'd3);
        expect_ev(EV_BYTE, 8'h34, 3'd4);
        expect_ev(EV_BYTE, 8'h12, 3'd4);
        expect_ev(EV_EOP, 8'h00, 3'd5);
        expect_ev(EV_DONE, 8'h00, 3'd0);
        r0 = req_cnt; c0 = crcen_cnt; k0 = clr_cnt;
        start(3'd1, 3);
        wait_idle(300, "data1_3");
        chk("data1_crc_enable", crcen_cnt - c0, 3);
        chk("data1_data_req", req_cnt - r0, 3);
        chk("data1_crc_clear", clr_cnt - k0, 1);

        // DATA0, empty payload
        crc_in = 16'h0000;
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, 8'hC3, 3'd2);
        expect_ev(EV_BYTE, 8'h00, 3'd4);
        expect_ev(EV_BYTE, 8'h00, 3'd4);
        expect_ev(EV_EOP, 8'h00, 3'd5);
        expect_ev(EV_DONE, 8'h00, 3'd0);
        r0 = req_cnt; c0 = crcen_cnt;
        start(3'd0, 0);
        wait_idle(200, "data0_0");
        chk("data0_0_data_req", req_cnt - r0, 0);
        chk("data0_0_crc_enable", crcen_cnt - c0, 0);

        handshake(3'd3, 8'h5A, "nak");
        handshake(3'd4, 8'h1E, "stall");

        reject(3'd6, 0, "rej_type6");
        reject(3'd0, MAXB + 1, "rej_oversize");

        // Full-size DATA0 with slow buffer and a stray start mid-packet
        dly = 5;
        crc_in = 16'hBEEF;
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, 8'hC3, 3'd2);
        for (int i = 0; i < MAXB; i++) begin
            buf_q.push_back(8'(i * 3 + 1));
            expect_ev(EV_BYTE, 8'(i * 3 + 1), 3'd3);
        end
        expect_ev(EV_BYTE, 8'hEF, 3'd4);
        expect_ev(EV_BYTE, 8'hBE, 3'd4);
        expect_ev(EV_EOP, 8'h00, 3'd5);
        expect_ev(EV_DONE, 8'h00, 3'd0);
        l0 = load_cnt; k0 = clr_cnt;
        start(3'd0, MAXB);
        wait_loads(l0 + 10, 500, "max_mid_wait");
        start(3'd2, 0);
        wait_idle(5000, "max_size");
        chk("max_size_loads", load_cnt - l0, MAXB + 4);
        chk("max_size_one_clear", clr_cnt - k0, 1);
        dly = 1;

        // Reset during the second payload byte
        crc_in = 16'h0000;
        buf_q.push_back(8'h11); buf_q.push_back(8'h22); buf_q.push_back(8'h33);
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, 8'hC3, 3'd2);
        expect_ev(EV_BYTE, 8'h11, 3'd3);
        expect_ev(EV_BYTE, 8'h22, 3'd3);
        l0 = load_cnt;
        start(3'd0, 3);
        wait_loads(l0 + 4, 200, "rst_mid_wait");
        n_rst = 1'b0;
        buf_q.delete();
        @(negedge clk);
        check_reset("rst_mid");
        chk("rst_mid_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check_no_pulse("rst_mid_release");
        handshake(3'd2, 8'hD2, "ack_after_rst");

`ifdef USB_TX_ABORT_EN
        buf_q.push_back(8'h11); buf_q.push_back(8'h22); buf_q.push_back(8'h33);
        expect_ev(EV_BYTE, 8'h80, 3'd1);
        expect_ev(EV_BYTE, 8'hC3, 3'd2);
        expect_ev(EV_BYTE, 8'h11, 3'd3);
        expect_ev(EV_BYTE, 8'h22, 3'd3);
        expect_ev(EV_EOP, 8'h00, 3'd5);
        expect_ev(EV_ERR, 8'h00, 3'd0);
        l0 = load_cnt;
        start(3'd0, 3);
        wait_loads(l0 + 4, 200, "abort_wait");
        tx_abort = 1'b1;
        @(posedge clk);
        #1;
        tx_abort = 1'b0;
        chk("abort_eop_next", int'(eop_req), 1);
        wait_idle(200, "abort");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
